// File: rtl/riscv_pkg.sv
// Shared RV32 constants and fetch-stage types, so fetch and decode draw on one source.
package riscv_pkg;
    localparam int ILEN = 32;
    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/gnt/rvalid channel, redirect input and decoder handshake.
interface instruction_fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            fetch_fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read combinationally from the storage array.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    assign rdata   = mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_reg] <= wdata;
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// In-order instruction fetch: PC, credit-limited memory requests, response buffer, redirect/kill.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_unit_if.master bus
);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     CREDITS = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   kill_reg, kill_next;

    logic [CW:0]          in_flight;
    logic                 req, grant, resp, resp_live, flush;
    logic                 ifb_push, ifb_pop, pcq_pop;
    logic [CW-1:0]        ifb_count, pcq_count;
    logic                 ifb_full, ifb_empty, pcq_full, pcq_empty;
    logic [XLEN-1:0]      pcq_head;
    logic [XLEN+ILEN-1:0] ifb_head;
    logic                 unused_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= BOOT;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            kill_reg        <= '0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            kill_reg        <= kill_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        outstanding_next = outstanding_reg;
        kill_next        = kill_reg;
        flush            = 1'b0;

        // Buffered words count against the credit so every response has a slot waiting.
        in_flight = {1'b0, outstanding_reg} + {1'b0, ifb_count};
        req       = (state_reg == RUN) && !bus.redirect_valid && (in_flight < CREDITS);
        grant     = req && bus.imem_gnt;
        resp      = bus.imem_rvalid && (outstanding_reg != '0);
        resp_live = resp && (kill_reg == '0);
        ifb_push  = resp_live && (state_reg == RUN) && !bus.redirect_valid;
        pcq_pop   = resp_live && !pcq_empty;

        if (resp)  outstanding_next = outstanding_next - ONE;
        if (grant) outstanding_next = outstanding_next + ONE;
        if (resp && (kill_reg != '0)) kill_next = kill_reg - ONE;
        if (grant) fetch_pc_next = fetch_pc_reg + XLEN'(4);
        if (state_reg == BOOT) state_next = RUN;

        // Every request still in flight after this cycle belongs to the old path.
        if (bus.redirect_valid && (state_reg != HALT)) begin
            flush         = 1'b1;
            kill_next     = outstanding_reg - (resp ? ONE : '0);
            fetch_pc_next = bus.redirect_pc;
            state_next    = is_word_aligned(bus.redirect_pc[1:0]) ? RUN : HALT;
        end
    end

    assign ifb_pop = !ifb_empty && bus.instr_ready;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (grant && !pcq_full),
        .wdata (fetch_pc_reg),
        .pop   (pcq_pop),
        .rdata (pcq_head),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    fetch_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(FIFO_DEPTH)) u_instr_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (ifb_push),
        .wdata ({pcq_head, bus.imem_rdata}),
        .pop   (ifb_pop),
        .rdata (ifb_head),
        .count (ifb_count),
        .full  (ifb_full),
        .empty (ifb_empty)
    );

    assign unused_status   = ^{pcq_count, ifb_full};

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc_reg;
    assign bus.instr_valid = !ifb_empty;
    assign bus.instr       = ifb_head[ILEN-1:0];
    assign bus.instr_pc    = ifb_head[XLEN+ILEN-1:ILEN];
    assign bus.fetch_fault = (state_reg == HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: memory model with in-order responses, epoch-tagged scoreboard, vector table.
module tb_instruction_fetch_unit;
    import riscv_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
    typedef struct {
        int ncyc; bit redir; logic [31:0] rpc; bit gnt; int lat; bit ready;
        bit exp_fault; bit chk_first;
    } vec_t;

    rsp_t        rsp_q[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    bit          gnt_en = 1'b1;
    bit          ready = 1'b1;
    bit          halted = 1'b0;
    bit          in_boot = 1'b1;
    bit          got_first = 1'b0;
    logic [31:0] first_grant = '0;
    logic [31:0] exp_pc = RST_PC;
    bit          obs_req, obs_valid, obs_fault;
    logic [31:0] obs_addr, obs_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        rsp_q.delete(); exp_q.delete();
        halted = 1'b0; in_boot = 1'b1; got_first = 1'b0; exp_pc = RST_PC;
        #1;
        check("rst_imem_req",    32'(bus.imem_req), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
        check("rst_imem_addr",   bus.imem_addr, RST_PC);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit stray);
        bit   fault_exp, resp_this, push_this, exp_req, exp_valid;
        int   sum;
        rsp_t r;
        exp_t e;
        fault_exp = halted;
        resp_this = 1'b0;
        push_this = 1'b0;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_gnt       = gnt_en;
        bus.instr_ready    = ready;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        if (redir && !halted) begin
            epoch++;
            exp_pc = rpc;
            if (rpc[1:0] != 2'b00) halted = 1'b1;
        end
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            resp_this = 1'b1;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = r.addr ^ KEY;
            if (r.epoch == epoch && !halted) begin
                exp_q.push_back('{pc: r.addr, word: r.addr ^ KEY});
                push_this = 1'b1;
            end
        end else if (stray) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        sum = rsp_q.size() + (resp_this ? 1 : 0) + exp_q.size() - (push_this ? 1 : 0);
        exp_req   = !in_boot && !halted && !redir && (sum < DEPTH);
        exp_valid = (exp_q.size() - (push_this ? 1 : 0)) > 0;
        #1;
        obs_req   = bus.imem_req;
        obs_valid = bus.instr_valid;
        obs_fault = bus.fetch_fault;
        obs_addr  = bus.imem_addr;
        obs_instr = bus.instr;
        check("imem_req",    32'(bus.imem_req),    32'(exp_req));
        check("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        check("fetch_fault", 32'(bus.fetch_fault), 32'(fault_exp));
        if (bus.imem_req && bus.imem_gnt) begin
            check("imem_addr", bus.imem_addr, exp_pc);
            if (!got_first) begin
                got_first = 1'b1;
                first_grant = bus.imem_addr;
            end
            rsp_q.push_back('{addr: bus.imem_addr, epoch: epoch, due: cyc + lat});
            exp_pc += 32'd4;
        end
        if (bus.instr_valid && bus.instr_ready && exp_valid) begin
            e = exp_q.pop_front();
            check("instr_pc", bus.instr_pc, e.pc);
            check("instr",    bus.instr,    e.word);
            pop_log.push_back(bus.instr_pc);
            $display("cyc=%0d instr pc=%h word=%h", cyc, bus.instr_pc, bus.instr);
        end
        if (redir && !fault_exp) exp_q.delete();
        in_boot = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs [8];
        logic [31:0] h0, a0;
        int          n;

        vecs[0] = '{4, 1'b0, 32'h0,         1'b1, 1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_0200, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, 1'b1, 32'h0000_0300, 1'b1, 2, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8, 1'b0, 32'h0,         1'b1, 2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5, 1'b0, 32'h0,         1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{6, 1'b1, 32'h0000_0400, 1'b1, 3, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8, 1'b1, 32'hFFFF_FFF8, 1'b1, 1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{6, 1'b0, 32'h0,         1'b1, 1, 1'b1, 1'b0, 1'b0};

        #1;
        do_reset();

        // Zero-wait memory; the BOOT cycle must not request.
        gnt_en = 1'b1; lat = 1; ready = 1'b1;
        step(1'b0, '0, 1'b0);
        check("boot_no_req", 32'(obs_req), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
        check("first_addr", first_grant, RST_PC);

        // Backpressure: head held, requests stop once the credit is used up.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        h0 = obs_instr;
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0);
        check("bp_valid", 32'(obs_valid), 32'd1);
        check("bp_head",  obs_instr, h0);
        check("bp_req",   32'(obs_req), 32'd0);
        ready = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);

        // Redirect with two requests in flight.
        lat = 3;
        n = 0;
        while (rsp_q.size() < 2 && n < 20) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (rsp_q.size() < 2) begin
            errors++;
            $display("FAIL setup_outstanding got=%0d want=2", rsp_q.size());
        end
        step(1'b1, 32'h0000_0100, 1'b0);
        pop_log.delete();
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b0);
        check("redir_first",  (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h0000_0100);
        check("redir_second", (pop_log.size() > 1) ? pop_log[1] : 32'hFFFF_FFFF, 32'h0000_0104);

        // Vector table.
        for (int v = 0; v < 8; v++) begin
            gnt_en = vecs[v].gnt; lat = vecs[v].lat; ready = vecs[v].ready;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                step(vecs[v].redir && (c == 0), vecs[v].rpc, 1'b0);
                if (c == 0) pop_log.delete();
            end
            check("vec_fault", 32'(obs_fault), 32'(vecs[v].exp_fault));
            if (vecs[v].chk_first)
                check("vec_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, vecs[v].rpc);
        end

        // Grant stall holds the address; stray rvalid with nothing outstanding is ignored.
        gnt_en = 1'b0; lat = 1; ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        a0 = obs_addr;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            check("stall_addr", obs_addr, a0);
            check("stall_req",  32'(obs_req), 32'd1);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("stray_valid", 32'(obs_valid), 32'd0);
        gnt_en = 1'b1;

        // Misaligned redirect halts fetching until reset.
        lat = 2;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0102, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        check("halt_fault", 32'(obs_fault), 32'd1);
        check("halt_req",   32'(obs_req),   32'd0);
        check("halt_valid", 32'(obs_valid), 32'd0);
        do_reset();
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0);
        check("post_halt_first", first_grant, RST_PC);

        // Asynchronous reset between clock edges in the middle of a burst.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        #2;
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        check("post_async_first", first_grant, RST_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
